// File: rtl/decode_pkg.sv
// decode_pkg: shared opcodes, instruction field positions, FSM states and the decoded slot record.
package decode_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_BR  = 4'hC;

    localparam int OPC_LSB  = 12;
    localparam int IMMF_BIT = 11;
    localparam int RD_LSB   = 8;
    localparam int RS1_LSB  = 5;
    localparam int RS2_LSB  = 2;
    localparam int IMM_LSB  = 0;

    // Widest PC the skid buffer can hold; narrower XLEN values are zero-extended into it.
    localparam int PC_W = 32;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

    typedef struct packed {
        logic            valid;
        logic [3:0]      opcode;
        logic            imm_flag;
        logic [2:0]      rd;
        logic [2:0]      rs1;
        logic [2:0]      rs2;
        logic [4:0]      imm;
        logic [PC_W-1:0] pc;
    } decoded_slot_t;

    function automatic decoded_slot_t crack(input logic v, input logic [15:0] instr, input logic [PC_W-1:0] pc);
        decoded_slot_t s;
        s.valid    = v;
        s.opcode   = instr[OPC_LSB +: 4];
        s.imm_flag = instr[IMMF_BIT];
        s.rd       = instr[RD_LSB +: 3];
        s.rs1      = instr[RS1_LSB +: 3];
        s.rs2      = instr[RS2_LSB +: 3];
        s.imm      = instr[IMM_LSB +: 5];
        s.pc       = pc;
        return s;
    endfunction

endpackage

// File: rtl/decode_slot.sv
// decode_slot: per-slot field extraction (or skid replay), register read with write-back bypass, branch target.
module decode_slot
    import decode_pkg::*;
#(
    parameter int XLEN = 16,
    parameter int RW   = 3,
    parameter int NWB  = 2
) (
    input  logic                  use_skid_i,
    input  decoded_slot_t         skid_i,
    input  logic                  valid_i,
    input  logic [15:0]           instr_i,
    input  logic [XLEN-1:0]       pc_i,
    input  logic [XLEN-1:0]       rdata1_i,
    input  logic [XLEN-1:0]       rdata2_i,
    input  logic [NWB-1:0]        wb_en_i,
    input  logic [NWB*RW-1:0]     wb_addr_i,
    input  logic [NWB*XLEN-1:0]   wb_data_i,
    output decoded_slot_t         slot_o,
    output logic [RW-1:0]         raddr1_o,
    output logic [RW-1:0]         raddr2_o,
    output logic [XLEN-1:0]       op1_o,
    output logic [XLEN-1:0]       op2_o,
    output logic [XLEN-1:0]       br_target_o
);

    logic [XLEN-1:0] rs2_val;

    assign slot_o      = use_skid_i ? skid_i : crack(valid_i, instr_i, PC_W'(pc_i));
    assign raddr1_o    = RW'(slot_o.rs1);
    assign raddr2_o    = RW'(slot_o.rs2);
    assign br_target_o = slot_o.pc[XLEN-1:0] + (XLEN'($signed(slot_o.imm)) << 1);

    // Operand select: later write-back ports override earlier ones and the register file.
    always_comb begin
        op1_o   = rdata1_i;
        rs2_val = rdata2_i;
        for (int k = 0; k < NWB; k++) begin
            if (wb_en_i[k] && wb_addr_i[k*RW +: RW] == raddr1_o) op1_o = wb_data_i[k*XLEN +: XLEN];
            if (wb_en_i[k] && wb_addr_i[k*RW +: RW] == raddr2_o) rs2_val = wb_data_i[k*XLEN +: XLEN];
        end
        op2_o = slot_o.imm_flag ? XLEN'(slot_o.imm) : rs2_val;
    end

endmodule

// File: rtl/decode_stage_nw.sv
// decode_stage_nw: N-wide decode stage with RAW bundle splitting, branch shadow kill and flush.
module decode_stage_nw
    import decode_pkg::*;
#(
    parameter int         ISSUE_WIDTH = 2,
    parameter int         XLEN        = 16,
    parameter int         NREGS       = 8,
    parameter logic [3:0] BR_OPCODE   = OP_BR,
    localparam int        W           = ISSUE_WIDTH,
    localparam int        RW          = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [W-1:0]          in_valid,
    input  logic [W*16-1:0]       in_instr,
    input  logic [W*XLEN-1:0]     in_pc,
    output logic                  in_ready,
    output logic [2*W*RW-1:0]     rf_raddr,
    input  logic [2*W*XLEN-1:0]   rf_rdata,
    input  logic [W-1:0]          wb_en,
    input  logic [W*RW-1:0]       wb_addr,
    input  logic [W*XLEN-1:0]     wb_data,
    output logic [W-1:0]          out_valid,
    input  logic                  out_ready,
    output logic [W*4-1:0]        out_opcode,
    output logic [W*RW-1:0]       out_rd,
    output logic [W*XLEN-1:0]     out_op1,
    output logic [W*XLEN-1:0]     out_op2,
    output logic [W-1:0]          out_imm_flag,
    output logic [W-1:0]          out_is_branch,
    output logic [W*XLEN-1:0]     out_br_target
);

    localparam int SK = (W > 1) ? W - 1 : 1;

    state_t          state_q, state_d;
    decoded_slot_t   skid_q [SK];
    decoded_slot_t   skid_d [SK];
    decoded_slot_t   skid_view [W];
    decoded_slot_t   cand [W];
    logic [XLEN-1:0] op1_w [W];
    logic [XLEN-1:0] op2_w [W];
    logic [XLEN-1:0] tgt_w [W];
    logic [W-1:0]    in_cv, ev, br, hz, iv;
    logic            has_hz, adv, alive, run;
    int              hj;

    logic [W-1:0]      valid_q, valid_d, immf_q, immf_d, isbr_q, isbr_d;
    logic [W*4-1:0]    opc_q, opc_d;
    logic [W*RW-1:0]   rd_q, rd_d;
    logic [W*XLEN-1:0] op1_q, op1_d, op2_q, op2_d, tgt_q, tgt_d;

    assign adv           = (valid_q == '0) || out_ready;
    assign in_ready      = adv && (state_q == ST_RUN);
    assign out_valid     = valid_q;
    assign out_opcode    = opc_q;
    assign out_rd        = rd_q;
    assign out_op1       = op1_q;
    assign out_op2       = op2_q;
    assign out_imm_flag  = immf_q;
    assign out_is_branch = isbr_q;
    assign out_br_target = tgt_q;

    // Incoming slots count only up to the first gap in in_valid.
    always_comb begin
        run = 1'b1;
        for (int k = 0; k < W; k++) begin
            run      = run & in_valid[k];
            in_cv[k] = run;
        end
    end

    for (genvar g = 0; g < W; g++) begin : g_slot
        if (g < W - 1) begin : g_sk
            assign skid_view[g] = skid_q[g];
        end else begin : g_nsk
            assign skid_view[g] = '0;
        end
        decode_slot #(.XLEN(XLEN), .RW(RW), .NWB(W)) u_slot (
            .use_skid_i  (state_q == ST_SPLIT),
            .skid_i      (skid_view[g]),
            .valid_i     (in_cv[g]),
            .instr_i     (in_instr[g*16 +: 16]),
            .pc_i        (in_pc[g*XLEN +: XLEN]),
            .rdata1_i    (rf_rdata[(2*g)*XLEN +: XLEN]),
            .rdata2_i    (rf_rdata[(2*g+1)*XLEN +: XLEN]),
            .wb_en_i     (wb_en),
            .wb_addr_i   (wb_addr),
            .wb_data_i   (wb_data),
            .slot_o      (cand[g]),
            .raddr1_o    (rf_raddr[(2*g)*RW +: RW]),
            .raddr2_o    (rf_raddr[(2*g+1)*RW +: RW]),
            .op1_o       (op1_w[g]),
            .op2_o       (op2_w[g]),
            .br_target_o (tgt_w[g])
        );
    end

    // Effective validity after the branch shadow, then the lowest slot reading an older slot's rd.
    always_comb begin
        alive = 1'b1;
        for (int k = 0; k < W; k++) begin
            br[k] = cand[k].opcode == BR_OPCODE;
            ev[k] = cand[k].valid && alive;
            alive = alive && ev[k] && !br[k];
        end
        for (int j = 0; j < W; j++) begin
            hz[j] = 1'b0;
            for (int i = 0; i < W; i++) begin
                if (i < j && ev[i] && !br[i] && ev[j] &&
                    (cand[j].rs1 == cand[i].rd || (!cand[j].imm_flag && cand[j].rs2 == cand[i].rd))) hz[j] = 1'b1;
            end
        end
        has_hz = |hz;
        hj     = W;
        for (int j = W - 1; j >= 0; j--) if (hz[j]) hj = j;
        for (int k = 0; k < W; k++) iv[k] = ev[k] && (k < hj);
    end

    // Next state: flush clears everything; otherwise when the output frees, issue the older part and skid the rest.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        opc_d   = opc_q;
        rd_d    = rd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        immf_d  = immf_q;
        isbr_d  = isbr_q;
        tgt_d   = tgt_q;
        for (int m = 0; m < SK; m++) skid_d[m] = skid_q[m];
        if (flush) begin
            state_d = ST_RUN;
            valid_d = '0;
            opc_d   = '0;
            rd_d    = '0;
            op1_d   = '0;
            op2_d   = '0;
            immf_d  = '0;
            isbr_d  = '0;
            tgt_d   = '0;
            for (int m = 0; m < SK; m++) skid_d[m] = '0;
        end else if (adv) begin
            state_d = has_hz ? ST_SPLIT : ST_RUN;
            valid_d = iv;
            for (int k = 0; k < W; k++) begin
                opc_d[k*4 +: 4]       = cand[k].opcode;
                rd_d[k*RW +: RW]      = RW'(cand[k].rd);
                op1_d[k*XLEN +: XLEN] = op1_w[k];
                op2_d[k*XLEN +: XLEN] = op2_w[k];
                immf_d[k]             = cand[k].imm_flag;
                isbr_d[k]             = br[k];
                tgt_d[k*XLEN +: XLEN] = tgt_w[k];
            end
            for (int m = 0; m < SK; m++) begin
                skid_d[m] = '0;
                if (has_hz && m + hj < W) begin
                    skid_d[m]       = cand[m + hj];
                    skid_d[m].valid = ev[m + hj];
                end
            end
        end
    end

    // State, skid buffer and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            valid_q <= '0;
            opc_q   <= '0;
            rd_q    <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            immf_q  <= '0;
            isbr_q  <= '0;
            tgt_q   <= '0;
            for (int m = 0; m < SK; m++) skid_q[m] <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            opc_q   <= opc_d;
            rd_q    <= rd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            immf_q  <= immf_d;
            isbr_q  <= isbr_d;
            tgt_q   <= tgt_d;
            for (int m = 0; m < SK; m++) skid_q[m] <= skid_d[m];
        end
    end

endmodule

// File: tb/tb_decode_stage_nw.sv
// tb_decode_stage_nw: directed stimulus checked against a list-based behavioural model of the decode stage.
module tb_decode_stage_nw;

    localparam int W  = 2;
    localparam int X  = 16;
    localparam int RW = 3;

    logic              clk, reset, flush, in_ready, out_ready;
    logic [W-1:0]      in_valid, wb_en, out_valid, out_imm_flag, out_is_branch;
    logic [W*16-1:0]   in_instr;
    logic [W*X-1:0]    in_pc, wb_data, out_op1, out_op2, out_br_target;
    logic [2*W*RW-1:0] rf_raddr;
    logic [2*W*X-1:0]  rf_rdata;
    logic [W*RW-1:0]   wb_addr, out_rd;
    logic [W*4-1:0]    out_opcode;

    logic [15:0] rf [8];
    int checks = 0;
    int errors = 0;

    logic [W-1:0] e_valid;
    logic [3:0]   e_opc [W];
    logic [2:0]   e_rd [W];
    logic [15:0]  e_op1 [W];
    logic [15:0]  e_op2 [W];
    logic [15:0]  e_tgt [W];
    logic         e_immf [W];
    logic         e_br [W];
    logic [15:0]  pq_i[$], pq_pc[$], li[$], lp[$];
    int           split;

    decode_stage_nw #(.ISSUE_WIDTH(W), .XLEN(X), .NREGS(8), .BR_OPCODE(4'hC)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode), .out_rd(out_rd),
        .out_op1(out_op1), .out_op2(out_op2), .out_imm_flag(out_imm_flag),
        .out_is_branch(out_is_branch), .out_br_target(out_br_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 2*W; k++) rf_rdata[k*X +: X] = rf[rf_raddr[k*RW +: RW]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] rr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, 1'b0, rd, rs1, rs2, 2'b00};
    endfunction

    function automatic logic [15:0] ri(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [4:0] imm);
        return {op, 1'b1, rd, rs1, imm};
    endfunction

    function automatic logic [15:0] rval(input logic [2:0] r);
        logic [15:0] v;
        v = rf[r];
        for (int k = 0; k < W; k++) if (wb_en[k] && wb_addr[k*RW +: RW] == r) v = wb_data[k*X +: X];
        return v;
    endfunction

    task automatic send(input logic [1:0] v, input logic [15:0] i0, input logic [15:0] i1, input logic [15:0] p0, input logic [15:0] p1);
        in_valid = v;
        in_instr = {i1, i0};
        in_pc    = {p1, p0};
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Model: pending list of instructions; each output slot group is the next run up to a RAW or branch.
    task automatic model_step;
        int s;
        if (reset || flush) begin
            e_valid = '0;
            pq_i.delete();
            pq_pc.delete();
        end else if (e_valid == '0 || out_ready) begin
            li.delete();
            lp.delete();
            if (pq_i.size() != 0) begin
                li = pq_i;
                lp = pq_pc;
            end else begin
                for (int k = 0; k < W; k++) begin
                    if (!in_valid[k]) break;
                    li.push_back(in_instr[k*16 +: 16]);
                    lp.push_back(in_pc[k*X +: X]);
                end
            end
            for (int n = 0; n < li.size(); n++) begin
                if (li[n][15:12] == 4'hC) begin
                    while (li.size() > n + 1) begin
                        void'(li.pop_back());
                        void'(lp.pop_back());
                    end
                    break;
                end
            end
            split = li.size();
            for (int j = li.size() - 1; j >= 1; j--)
                for (int i = 0; i < j; i++)
                    if (li[i][15:12] != 4'hC && (li[j][7:5] == li[i][10:8] || (!li[j][11] && li[j][4:2] == li[i][10:8]))) split = j;
            e_valid = '0;
            for (int k = 0; k < split; k++) begin
                e_valid[k] = 1'b1;
                e_opc[k]   = li[k][15:12];
                e_rd[k]    = li[k][10:8];
                e_immf[k]  = li[k][11];
                e_br[k]    = li[k][15:12] == 4'hC;
                e_op1[k]   = rval(li[k][7:5]);
                e_op2[k]   = li[k][11] ? 16'(li[k][4:0]) : rval(li[k][4:2]);
                s          = li[k][4] ? int'(li[k][4:0]) - 32 : int'(li[k][4:0]);
                e_tgt[k]   = 16'(int'(lp[k]) + 2 * s);
            end
            pq_i.delete();
            pq_pc.delete();
            for (int n = split; n < li.size(); n++) begin
                pq_i.push_back(li[n]);
                pq_pc.push_back(lp[n]);
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            chk("in_ready", in_ready, (e_valid == '0 || out_ready) && pq_i.size() == 0);
            chk("out_valid", out_valid, e_valid);
            for (int k = 0; k < W; k++) begin
                if (e_valid[k]) begin
                    chk($sformatf("opcode%0d", k), out_opcode[k*4 +: 4], e_opc[k]);
                    chk($sformatf("rd%0d", k), out_rd[k*RW +: RW], e_rd[k]);
                    chk($sformatf("op1_%0d", k), out_op1[k*X +: X], e_op1[k]);
                    chk($sformatf("op2_%0d", k), out_op2[k*X +: X], e_op2[k]);
                    chk($sformatf("immf%0d", k), out_imm_flag[k], e_immf[k]);
                    chk($sformatf("isbr%0d", k), out_is_branch[k], e_br[k]);
                    chk($sformatf("tgt%0d", k), out_br_target[k*X +: X], e_tgt[k]);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = '0; in_instr = '0; in_pc = '0;
        wb_en = '0; wb_addr = '0; wb_data = '0;
        for (int r = 0; r < 8; r++) rf[r] = 16'h100 + 16'(r);
        rf[1] = 16'd5;
        rf[2] = 16'd7;
        tick; tick;
        reset = 1'b0;
        chk("rst_valid", out_valid, 2'b00);
        chk("rst_opcode", out_opcode, 8'h00);
        chk("rst_target", out_br_target, 32'h0);
        chk("rst_ready", in_ready, 1'b1);
        send(2'b11, rr(4'h1, 3'd3, 3'd1, 3'd2), ri(4'h2, 3'd4, 3'd1, 5'd3), 16'h0, 16'h2);
        tick;
        send(2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        chk("t1_valid", out_valid, 2'b11);
        chk("t1_op1_0", out_op1[15:0], 16'd5);
        chk("t1_op2_0", out_op2[15:0], 16'd7);
        chk("t1_op1_1", out_op1[31:16], 16'd5);
        chk("t1_op2_1", out_op2[31:16], 16'd3);
        send(2'b11, rr(4'h1, 3'd3, 3'd1, 3'd2), rr(4'h3, 3'd5, 3'd3, 3'd1), 16'h4, 16'h6);
        tick;
        chk("t2_valid_a", out_valid, 2'b01);
        chk("t2_ready_a", in_ready, 1'b0);
        send(2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        tick;
        chk("t2_valid_b", out_valid, 2'b01);
        chk("t2_opc_b", out_opcode[3:0], 4'h3);
        chk("t2_op1_b", out_op1[15:0], 16'h103);
        chk("t2_ready_b", in_ready, 1'b1);
        send(2'b01, rr(4'h1, 3'd6, 3'd1, 3'd2), 16'h0, 16'h8, 16'h0);
        wb_en = 2'b01; wb_addr = {3'd0, 3'd1}; wb_data = {16'd0, 16'd9};
        tick;
        chk("t3_byp", out_op1[15:0], 16'd9);
        wb_en = 2'b11; wb_addr = {3'd1, 3'd1}; wb_data = {16'h22, 16'd9};
        tick;
        chk("t3_byp_hi", out_op1[15:0], 16'h22);
        wb_en = '0;
        send(2'b11, {4'hC, 1'b0, 3'd0, 3'd1, 5'h1E}, rr(4'h1, 3'd2, 3'd1, 3'd1), 16'h10, 16'h12);
        tick;
        send(2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        chk("t4_target", out_br_target[15:0], 16'h000C);
        chk("t4_isbr", out_is_branch[0], 1'b1);
        chk("t4_valid", out_valid, 2'b01);
        send(2'b01, rr(4'h4, 3'd7, 3'd2, 3'd2), 16'h0, 16'h20, 16'h0);
        tick;
        out_ready = 1'b0;
        send(2'b01, rr(4'h5, 3'd6, 3'd1, 3'd2), 16'h0, 16'h22, 16'h0);
        tick; tick; tick;
        chk("t5_hold_opc", out_opcode[3:0], 4'h4);
        chk("t5_hold_op1", out_op1[15:0], 16'd7);
        chk("t5_hold_rdy", in_ready, 1'b0);
        out_ready = 1'b1;
        tick;
        send(2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        chk("t5_next_opc", out_opcode[3:0], 4'h5);
        send(2'b11, rr(4'h1, 3'd3, 3'd1, 3'd2), rr(4'h3, 3'd5, 3'd3, 3'd1), 16'h30, 16'h32);
        tick;
        flush = 1'b1;
        send(2'b01, rr(4'h6, 3'd1, 3'd2, 3'd2), 16'h0, 16'h34, 16'h0);
        tick;
        flush = 1'b0;
        send(2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        chk("t6_flush_valid", out_valid, 2'b00);
        chk("t6_flush_ready", in_ready, 1'b1);
        tick;
        chk("t6_no_stale", out_valid, 2'b00);
        send(2'b10, rr(4'h1, 3'd1, 3'd1, 3'd1), rr(4'h2, 3'd2, 3'd2, 3'd2), 16'h40, 16'h42);
        tick;
        chk("gap_valid", out_valid, 2'b00);
        send(2'b11, rr(4'h1, 3'd3, 3'd1, 3'd2), rr(4'h3, 3'd5, 3'd3, 3'd1), 16'h50, 16'h52);
        tick;
        send(2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        #2 reset = 1'b1;
        #1 chk("t6_async_rst", out_valid, 2'b00);
        tick;
        reset = 1'b0;
        tick;
        chk("t6_rst_no_stale", out_valid, 2'b00);
        chk("t6_rst_ready", in_ready, 1'b1);
        send(2'b11, rr(4'h1, 3'd3, 3'd1, 3'd2), ri(4'h2, 3'd4, 3'd1, 5'd3), 16'h60, 16'h62);
        tick;
        send(2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        chk("post_rst_valid", out_valid, 2'b11);
        tick; tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
